// File: rtl/except_seq.sv
// except_seq
//   Sequences exception / ERET handling downstream of the exception-request
//   unit. One request is latched in IDLE, the pipeline is flushed and CP0 is
//   committed in a single COMMIT cycle, outstanding data-bus transactions are
//   drained, and fetch is redirected to the vector (or EPC/ErrorEPC for ERET)
//   through a valid/ready handshake.
//
//   Optional feature: define EXCEPT_SEQ_WDOG_EN to enable the drain watchdog.
//   When enabled, DRAIN gives up after WDOG_CYCLES cycles, raises the sticky
//   drain_timeout flag and forgets the outstanding transactions. When not
//   defined, DRAIN waits indefinitely and drain_timeout is tied low.
//
// Parameters
//   OUTST_W      width of the outstanding-dbus counter (saturates at 2**OUTST_W-1)
//   WDOG_CYCLES  drain watchdog limit in cycles (>= 1, watchdog build only)
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   except_valid/eret/code/pc/delayslot/extra/vec
//                               exception request and payload (sampled in IDLE)
//   dbus_issue, dbus_resp       data-bus request accepted / response returned
//   flush, stall_front          one-cycle flush pulse, front-end hold while busy
//   cp0_we, cp0_eret            one-cycle commit strobes to CP0
//   cp0_exc_code/epc/bd/badvaddr latched CP0 payload (held until next latch)
//   redirect_valid/pc/ready     fetch redirect handshake
//   busy                        sequencer not in IDLE
//   drain_timeout               sticky watchdog flag
module except_seq #(
  parameter int OUTST_W     = 3,
  parameter int WDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        except_valid,
  input  logic        except_eret,
  input  logic [4:0]  except_code,
  input  logic [31:0] except_pc,
  input  logic        except_delayslot,
  input  logic [31:0] except_extra,
  input  logic [31:0] except_vec,
  input  logic        dbus_issue,
  input  logic        dbus_resp,
  output logic        flush,
  output logic        stall_front,
  output logic        cp0_we,
  output logic        cp0_eret,
  output logic [4:0]  cp0_exc_code,
  output logic [31:0] cp0_epc,
  output logic        cp0_bd,
  output logic [31:0] cp0_badvaddr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy,
  output logic        drain_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_DRAIN,
    ST_REDIRECT
  } state_t;

  localparam logic [OUTST_W-1:0] COUNT_MAX = '1;
  localparam logic [OUTST_W-1:0] COUNT_ONE = {{(OUTST_W-1){1'b0}}, 1'b1};

  if (WDOG_CYCLES < 1) begin : g_wdog_check
    $error("except_seq: WDOG_CYCLES must be at least 1");
  end

  state_t             state_reg, state_next;
  logic [OUTST_W-1:0] count_reg, count_upd, count_next;
  logic               latch_en;
  logic               wdog_fire;

  logic               eret_reg;
  logic [4:0]         code_reg;
  logic [31:0]        epc_reg;
  logic               bd_reg;
  logic [31:0]        badvaddr_reg;
  logic [31:0]        vec_reg;

  // Outstanding dbus counter: simultaneous issue/resp cancel out, and both
  // ends saturate instead of wrapping.
  always_comb begin
    count_upd = count_reg;
    if (dbus_issue && !dbus_resp && (count_reg != COUNT_MAX)) begin
      count_upd = count_reg + COUNT_ONE;
    end else if (dbus_resp && !dbus_issue && (count_reg != '0)) begin
      count_upd = count_reg - COUNT_ONE;
    end
  end

  // A watchdog expiry abandons whatever is still outstanding.
  assign count_next = wdog_fire ? '0 : count_upd;

`ifdef EXCEPT_SEQ_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              timeout_reg;

  // Counts DRAIN cycles already spent; restarts from zero on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if ((state_reg == ST_DRAIN) && (state_next == ST_DRAIN)) begin
        wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
      end else begin
        wdog_cnt_reg <= '0;
      end
      if (wdog_fire) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign drain_timeout = timeout_reg;
`else
  assign drain_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Payload is captured once per request and held until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eret_reg     <= 1'b0;
      code_reg     <= '0;
      epc_reg      <= '0;
      bd_reg       <= 1'b0;
      badvaddr_reg <= '0;
      vec_reg      <= '0;
    end else if (latch_en) begin
      eret_reg     <= except_eret;
      code_reg     <= except_code;
      epc_reg      <= except_delayslot ? (except_pc - 32'd4) : except_pc;
      bd_reg       <= except_delayslot;
      badvaddr_reg <= except_extra;
      vec_reg      <= except_vec;
    end
  end

  // Next-state and strobe decode. COMMIT and DRAIN look at the counter value
  // at the end of the current cycle so a response arriving now is counted.
  always_comb begin
    state_next     = state_reg;
    latch_en       = 1'b0;
    wdog_fire      = 1'b0;
    flush          = 1'b0;
    cp0_we         = 1'b0;
    cp0_eret       = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (except_valid) begin
          latch_en   = 1'b1;
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        flush      = 1'b1;
        cp0_we     = !eret_reg;
        cp0_eret   = eret_reg;
        state_next = (count_upd == '0) ? ST_REDIRECT : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (count_upd == '0) begin
          state_next = ST_REDIRECT;
        end
`ifdef EXCEPT_SEQ_WDOG_EN
        else if (wdog_cnt_reg == WDOG_LAST) begin
          wdog_fire  = 1'b1;
          state_next = ST_REDIRECT;
        end
`endif
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy         = (state_reg != ST_IDLE);
  assign stall_front  = busy;
  assign cp0_exc_code = code_reg;
  assign cp0_epc      = epc_reg;
  assign cp0_bd       = bd_reg;
  assign cp0_badvaddr = badvaddr_reg;
  assign redirect_pc  = vec_reg;

endmodule

// File: tb/tb_except_seq.sv
// Directed testbench for except_seq. Cycle cN is the interval starting 1 time
// unit after the Nth rising edge counted from the request cycle c0; inputs are
// driven and outputs sampled there.
module tb_except_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        except_valid, except_eret, except_delayslot;
  logic [4:0]  except_code;
  logic [31:0] except_pc, except_extra, except_vec;
  logic        dbus_issue, dbus_resp;
  logic        flush, stall_front, cp0_we, cp0_eret, cp0_bd;
  logic [4:0]  cp0_exc_code;
  logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;
  logic        redirect_valid, redirect_ready, busy, drain_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  except_seq #(.OUTST_W(3), .WDOG_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .except_valid(except_valid), .except_eret(except_eret),
    .except_code(except_code), .except_pc(except_pc),
    .except_delayslot(except_delayslot), .except_extra(except_extra),
    .except_vec(except_vec),
    .dbus_issue(dbus_issue), .dbus_resp(dbus_resp),
    .flush(flush), .stall_front(stall_front),
    .cp0_we(cp0_we), .cp0_eret(cp0_eret),
    .cp0_exc_code(cp0_exc_code), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
    .cp0_badvaddr(cp0_badvaddr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .busy(busy), .drain_timeout(drain_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic eret, input logic [4:0] code, input logic [31:0] pc,
                     input logic ds, input logic [31:0] extra, input logic [31:0] vec);
    except_valid     = 1'b1;
    except_eret      = eret;
    except_code      = code;
    except_pc        = pc;
    except_delayslot = ds;
    except_extra     = extra;
    except_vec       = vec;
  endtask

  initial begin
    rst_n = 1'b0;
    except_valid = 1'b0; except_eret = 1'b0; except_delayslot = 1'b0;
    except_code = '0; except_pc = '0; except_extra = '0; except_vec = '0;
    dbus_issue = 1'b0; dbus_resp = 1'b0; redirect_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst busy", busy, 0);
    check("rst flush", flush, 0);
    check("rst redirect_valid", redirect_valid, 0);
    check("rst cp0_epc", cp0_epc, 0);
    check("rst redirect_pc", redirect_pc, 0);
    check("rst drain_timeout", drain_timeout, 0);
    rst_n = 1'b1;
    step();

    // 1. Syscall, nothing outstanding: minimum latency
    req(0, 5'd8, 32'h8000_1000, 0, 32'h0000_1234, 32'h8000_0180);
    step();                                    // c1
    except_valid = 1'b0;
    check("t1 c1 flush", flush, 1);
    check("t1 c1 cp0_we", cp0_we, 1);
    check("t1 c1 cp0_eret", cp0_eret, 0);
    check("t1 c1 cp0_epc", cp0_epc, 32'h8000_1000);
    check("t1 c1 cp0_bd", cp0_bd, 0);
    check("t1 c1 exc_code", cp0_exc_code, 8);
    check("t1 c1 badvaddr", cp0_badvaddr, 32'h0000_1234);
    check("t1 c1 stall_front", stall_front, 1);
    check("t1 c1 redirect_valid", redirect_valid, 0);
    step();                                    // c2
    check("t1 c2 redirect_valid", redirect_valid, 1);
    check("t1 c2 redirect_pc", redirect_pc, 32'h8000_0180);
    check("t1 c2 flush", flush, 0);
    check("t1 c2 cp0_we", cp0_we, 0);
    step();                                    // c3
    check("t1 c3 busy", busy, 0);
    check("t1 c3 redirect_valid", redirect_valid, 0);

    // 2. Delay slot: EPC points at the branch
    req(0, 5'd4, 32'h8000_1004, 1, 32'h0, 32'h8000_0180);
    step();
    except_valid = 1'b0;
    check("t2 c1 cp0_epc", cp0_epc, 32'h8000_1000);
    check("t2 c1 cp0_bd", cp0_bd, 1);
    step(); step();
    check("t2 c3 busy", busy, 0);
    check("t2 c3 epc held", cp0_epc, 32'h8000_1000);
    check("t2 c3 bd held", cp0_bd, 1);

`ifndef EXCEPT_SEQ_WDOG_EN
    // 3. Drain: two issues before c0, responses at c4 and c6; issue+resp at c3
    dbus_issue = 1'b1;
    step(); step();
    dbus_issue = 1'b0;
    req(0, 5'd12, 32'h8000_2000, 0, 32'h0, 32'h8000_0180);
    step();                                    // c1
    except_valid = 1'b0;
    check("t3 c1 flush", flush, 1);
    step();                                    // c2
    check("t3 c2 busy", busy, 1);
    check("t3 c2 redirect_valid", redirect_valid, 0);
    step();                                    // c3
    dbus_issue = 1'b1; dbus_resp = 1'b1;
    step();                                    // c4
    dbus_issue = 1'b0; dbus_resp = 1'b1;
    step();                                    // c5
    dbus_resp = 1'b0;
    check("t3 c5 redirect_valid", redirect_valid, 0);
    step();                                    // c6
    dbus_resp = 1'b1;
    check("t3 c6 redirect_valid", redirect_valid, 0);
    step();                                    // c7
    dbus_resp = 1'b0;
    check("t3 c7 redirect_valid", redirect_valid, 1);
    step();                                    // c8
    check("t3 c8 busy", busy, 0);
    check("t3 drain_timeout", drain_timeout, 0);

    // Saturation: 9 issues leave the counter at 7, so 7 responses drain it
    dbus_issue = 1'b1;
    repeat (9) step();
    dbus_issue = 1'b0;
    dbus_resp  = 1'b1;                         // responses c0..c6
    req(0, 5'd8, 32'h8000_3000, 0, 32'h0, 32'h8000_0180);
    step();                                    // c1
    except_valid = 1'b0;
    repeat (5) step();                         // c6
    check("sat c6 redirect_valid", redirect_valid, 0);
    check("sat c6 busy", busy, 1);
    step();                                    // c7 (resp continues into empty counter)
    check("sat c7 redirect_valid", redirect_valid, 1);
    step();                                    // c8
    dbus_resp = 1'b0;
    check("sat c8 busy", busy, 0);
    // Counter must have stayed at 0 despite extra responses
    req(0, 5'd8, 32'h8000_4000, 0, 32'h0, 32'h8000_0180);
    step();
    except_valid = 1'b0;
    step();
    check("underflow c2 redirect_valid", redirect_valid, 1);
    step();
`else
    // 6. Watchdog: one issue that never returns
    dbus_issue = 1'b1;
    step();
    dbus_issue = 1'b0;
    req(0, 5'd8, 32'h8000_5000, 0, 32'h0, 32'h8000_0180);
    step();                                    // c1
    except_valid = 1'b0;
    repeat (4) step();                         // c5, last DRAIN cycle
    check("wdog c5 redirect_valid", redirect_valid, 0);
    check("wdog c5 drain_timeout", drain_timeout, 0);
    step();                                    // c6
    check("wdog c6 redirect_valid", redirect_valid, 1);
    check("wdog c6 drain_timeout", drain_timeout, 1);
    step();
    check("wdog c7 busy", busy, 0);
    check("wdog sticky", drain_timeout, 1);
`endif

    // 4. Backpressure: ready low c2..c4
    req(0, 5'd8, 32'h8000_6000, 0, 32'h0, 32'h8000_0200);
    redirect_ready = 1'b0;
    step();
    except_valid = 1'b0;
    step();                                    // c2
    check("t4 c2 redirect_valid", redirect_valid, 1);
    check("t4 c2 redirect_pc", redirect_pc, 32'h8000_0200);
    step();                                    // c3
    check("t4 c3 redirect_valid", redirect_valid, 1);
    step();                                    // c4
    check("t4 c4 redirect_valid", redirect_valid, 1);
    check("t4 c4 redirect_pc", redirect_pc, 32'h8000_0200);
    step();                                    // c5
    redirect_ready = 1'b1;
    check("t4 c5 redirect_valid", redirect_valid, 1);
    step();                                    // c6
    check("t4 c6 busy", busy, 0);
    check("t4 c6 redirect_valid", redirect_valid, 0);

    // 5. ERET; a new request at c1 must be ignored
    req(1, 5'd0, 32'h8000_7000, 0, 32'h0, 32'h8000_2000);
    step();                                    // c1
    check("t5 c1 cp0_eret", cp0_eret, 1);
    check("t5 c1 cp0_we", cp0_we, 0);
    req(0, 5'd9, 32'h1234_5678, 1, 32'h0, 32'hDEAD_0000);
    step();                                    // c2
    except_valid = 1'b0;
    check("t5 c2 redirect_pc", redirect_pc, 32'h8000_2000);
    check("t5 c2 cp0_epc", cp0_epc, 32'h8000_7000);
    step();                                    // c3
    check("t5 c3 busy", busy, 0);
    step();                                    // c4
    check("t5 c4 still idle", busy, 0);

    // Asynchronous reset while draining
    dbus_issue = 1'b1;
    step();
    dbus_issue = 1'b0;
    req(0, 5'd8, 32'h8000_8000, 1, 32'h5555_0000, 32'h8000_0180);
    step();                                    // c1
    except_valid = 1'b0;
    step();                                    // c2, DRAIN
    check("ar c2 busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar busy", busy, 0);
    check("ar stall_front", stall_front, 0);
    check("ar redirect_valid", redirect_valid, 0);
    check("ar cp0_epc", cp0_epc, 0);
    check("ar cp0_bd", cp0_bd, 0);
    check("ar cp0_badvaddr", cp0_badvaddr, 0);
    check("ar redirect_pc", redirect_pc, 0);
    check("ar drain_timeout", drain_timeout, 0);
    step(); step();
    check("ar held cp0_we", cp0_we, 0);
    check("ar held flush", flush, 0);
    rst_n = 1'b1;
    step();
    // Counter was cleared by reset: no drain
    req(0, 5'd8, 32'h8000_9000, 0, 32'h0, 32'h8000_0180);
    step();
    except_valid = 1'b0;
    step();
    check("post-reset c2 redirect_valid", redirect_valid, 1);
    step();
    check("post-reset c3 busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
